// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache miss controller: address geometry,
// FSM state encoding and address-split helpers.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 2;
  localparam int SET_W    = 2;
  localparam int NUM_SET  = 1 << SET_W;
  localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W;

  // Kept as plain 2-bit constants so older tools and netlist viewers see the
  // raw encoding.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WRITEBACK = 2'd1;
  localparam state_t ST_REFILL    = 2'd2;
  localparam state_t ST_FILL      = 2'd3;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:SET_W+OFFSET_W];
  endfunction

  function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_W-1:0] addr);
    return addr[SET_W+OFFSET_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/lru_table.sv
// One LRU bit per set of a 2-way cache. The bit names the least-recently-used
// way. Combinational read port, single synchronous update port.
module lru_table #(
  parameter int NUM_SET = 4,
  parameter int SET_W   = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SET_W-1:0] rd_set_i,
  output logic             rd_lru_o,
  input  logic             upd_en_i,
  input  logic [SET_W-1:0] upd_set_i,
  input  logic             upd_lru_i
);

  logic [NUM_SET-1:0] lru_q;

  // Update the addressed set's LRU bit; all bits clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lru_q <= '0;
    end else if (upd_en_i) begin
      lru_q[upd_set_i] <= upd_lru_i;
    end
  end

  assign rd_lru_o = lru_q[rd_set_i];

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for the 2-way set-associative data cache. Detects misses,
// stalls the pipeline, picks a victim, writes back a dirty victim, refills
// the line from data memory and installs it in the arrays.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | accepting requests; hits update LRU only
// WRITEBACK | dirty victim being written to memory
// REFILL    | missed word being read from memory
// FILL      | one cycle: install line in the arrays
module cache_miss_ctrl #(
  parameter int NUM_SET = 4,
  parameter int TAG_W   = 28
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  input  logic             req_write_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic             hit_i,
  input  logic             hit_way_i,
  input  logic [1:0]       way_valid_i,
  input  logic             victim_dirty_i,
  input  logic [TAG_W-1:0] victim_tag_i,
  input  logic [31:0]      victim_data_i,
  output logic             victim_way_o,
  output logic             stall_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_valid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             fill_en_o,
  output logic             fill_way_o,
  output logic [TAG_W-1:0] fill_tag_o,
  output logic [31:0]      fill_data_o,
  output logic             fill_dirty_o
);

  import cache_pkg::*;

  state_t             state_q, state_d;
  logic [31:2]        addr_q, addr_d;
  logic               write_q, write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               way_q, way_d;
  logic [TAG_W-1:0]   vtag_q, vtag_d;
  logic [31:0]        vdata_q, vdata_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        addr_full_q;
  logic [SET_W-1:0]   set_sel;
  logic               lru_rd;
  logic               lru_upd_en;
  logic [SET_W-1:0]   lru_upd_set;
  logic               lru_upd_val;
  logic               miss;
  logic               unused_addr_lsb;

  // Byte-offset bits never matter: the line is one word.
  assign unused_addr_lsb = ^req_addr_i[1:0];

  assign addr_full_q = {addr_q, 2'b00};
  assign miss        = req_valid_i && !hit_i;

  // While a miss is in flight the latched set stays authoritative.
  assign set_sel = (state_q == ST_IDLE) ? addr_set(req_addr_i) : addr_set(addr_full_q);

  lru_table #(
    .NUM_SET (NUM_SET),
    .SET_W   (SET_W)
  ) u_lru (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_set_i  (set_sel),
    .rd_lru_o  (lru_rd),
    .upd_en_i  (lru_upd_en),
    .upd_set_i (lru_upd_set),
    .upd_lru_i (lru_upd_val)
  );

  // Victim choice: an invalid way first, otherwise the LRU way of the set.
  always_comb begin
    victim_way_o = lru_rd;
    if (!way_valid_i[0]) begin
      victim_way_o = 1'b0;
    end else if (!way_valid_i[1]) begin
      victim_way_o = 1'b1;
    end
  end

  // Next-state, miss latching and LRU update decisions.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    way_d       = way_q;
    vtag_d      = vtag_q;
    vdata_d     = vdata_q;
    rdata_d     = rdata_q;
    lru_upd_en  = 1'b0;
    lru_upd_set = addr_set(addr_full_q);
    lru_upd_val = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && hit_i) begin
          lru_upd_en  = 1'b1;
          lru_upd_set = addr_set(req_addr_i);
          lru_upd_val = ~hit_way_i;
        end else if (miss) begin
          addr_d  = req_addr_i[31:2];
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          way_d   = victim_way_o;
          vtag_d  = victim_tag_i;
          vdata_d = victim_data_i;
          // Only a valid and dirty victim needs to go back to memory.
          if (way_valid_i[victim_way_o] && victim_dirty_i) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_REFILL;
          end
        end
      end
      ST_WRITEBACK: begin
        if (mem_valid_i) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_valid_i) begin
          rdata_d = mem_rdata_i;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        lru_upd_en  = 1'b1;
        lru_upd_set = addr_set(addr_full_q);
        lru_upd_val = ~way_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched miss context.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      way_q   <= 1'b0;
      vtag_q  <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      way_q   <= way_d;
      vtag_q  <= vtag_d;
      vdata_q <= vdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode. Stall is gated by reset so it drops the instant reset
  // asserts, even if a miss request is presented at that moment.
  always_comb begin
    stall_o      = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    fill_en_o    = 1'b0;
    fill_way_o   = 1'b0;
    fill_tag_o   = '0;
    fill_data_o  = '0;
    fill_dirty_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_o = miss && rst_ni;
      end
      ST_WRITEBACK: begin
        stall_o     = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {vtag_q, addr_set(addr_full_q), 2'b00};
        mem_wdata_o = vdata_q;
      end
      ST_REFILL: begin
        stall_o    = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = addr_full_q;
      end
      ST_FILL: begin
        stall_o      = 1'b1;
        fill_en_o    = 1'b1;
        fill_way_o   = way_q;
        fill_tag_o   = addr_tag(addr_full_q);
        // Write-allocate: a store miss installs its own data, already dirty.
        fill_data_o  = write_q ? wdata_q : rdata_q;
        fill_dirty_o = write_q;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: hits, clean/dirty/store misses,
// idle mem_valid, and reset in the middle of a refill.
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, hit, hit_way, victim_dirty;
  logic [31:0] req_addr, req_wdata, victim_data;
  logic [1:0]  way_valid;
  logic [27:0] victim_tag;
  logic        victim_way, stall, mem_read, mem_write, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        fill_en, fill_way, fill_dirty;
  logic [27:0] fill_tag;
  logic [31:0] fill_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl #(.NUM_SET(4), .TAG_W(28)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_write_i    (req_write),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .hit_i          (hit),
    .hit_way_i      (hit_way),
    .way_valid_i    (way_valid),
    .victim_dirty_i (victim_dirty),
    .victim_tag_i   (victim_tag),
    .victim_data_i  (victim_data),
    .victim_way_o   (victim_way),
    .stall_o        (stall),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_valid_i    (mem_valid),
    .mem_rdata_i    (mem_rdata),
    .fill_en_o      (fill_en),
    .fill_way_o     (fill_way),
    .fill_tag_o     (fill_tag),
    .fill_data_o    (fill_data),
    .fill_dirty_o   (fill_dirty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; hit = 1'b0; hit_way = 1'b0; way_valid = 2'b11;
    victim_dirty = 1'b0; victim_tag = 28'h0; victim_data = 32'h0;
    mem_valid = 1'b0; mem_rdata = 32'h0;
    #2;
    total++;
    if ({stall, mem_read, mem_write, fill_en} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctl got=%b exp=0000", {stall, mem_read, mem_write, fill_en});
    end
    total++;
    if ({mem_addr, mem_wdata, fill_data} !== 96'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, fill_data});
    end
    total++;
    if (victim_way !== 1'b0) begin
      bad++; $display("FAIL reset_victim got=%b exp=0", victim_way);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_hit();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; hit = 1'b1;
    hit_way = 1'b0; way_valid = 2'b01;
    #1;
    total++;
    if ({stall, mem_read, mem_write, fill_en} !== 4'b0000) begin
      bad++; $display("FAIL hit_ctl got=%b exp=0000", {stall, mem_read, mem_write, fill_en});
    end
    step();
    // Hits on way0 in sets 2 and 3 so that the reset test can see them cleared.
    req_addr = 32'h08; way_valid = 2'b11;
    step();
    req_addr = 32'h0C;
    step();
    // No request: a hit indication must not touch the LRU.
    req_valid = 1'b0; req_addr = 32'h10; hit = 1'b1; hit_way = 1'b1;
    step();
    hit = 1'b0;
    for (int s = 0; s < 4; s++) begin
      req_addr = s << 2;
      #1;
      total++;
      if (victim_way !== ((s == 1) ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL hit_lru set=%0d got=%b exp=%b", s, victim_way, (s == 1) ? 1'b0 : 1'b1);
      end
    end
    step();
  endtask

  task automatic test_clean_miss();
    int stall_cnt = 0, rd_cnt = 0, fill_cnt = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h24; hit = 1'b0;
    way_valid = 2'b00; victim_dirty = 1'b0; victim_tag = 28'h0; victim_data = 32'h0;
    #1;
    total++;
    if ({stall, victim_way, mem_read} !== 3'b100) begin
      bad++; $display("FAIL clean_miss_detect got=%b exp=100", {stall, victim_way, mem_read});
    end
    if (stall) stall_cnt++;
    step();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFF0; way_valid = 2'b11;
    for (int cyc = 0; cyc < 20; cyc++) begin
      mem_valid = mem_read && (rd_cnt == 2);
      mem_rdata = mem_valid ? 32'hDEADBEEF : 32'h0;
      #1;
      if (stall) stall_cnt++;
      if (mem_read) begin
        rd_cnt++;
        total++;
        if ({mem_write, mem_addr} !== {1'b0, 32'h24}) begin
          bad++; $display("FAIL clean_rd_addr got=%b/%h exp=0/00000024", mem_write, mem_addr);
        end
      end
      if (fill_en) begin
        fill_cnt++;
        total++;
        if ({fill_way, fill_data, fill_dirty, fill_tag} !== {1'b0, 32'hDEADBEEF, 1'b0, 28'h2}) begin
          bad++; $display("FAIL clean_fill got=%b/%h/%b/%h exp=0/deadbeef/0/0000002",
                          fill_way, fill_data, fill_dirty, fill_tag);
        end
      end
      if (!stall) break;
      step();
    end
    mem_valid = 1'b0;
    total++;
    if ({rd_cnt, fill_cnt, stall_cnt} !== {32'd3, 32'd1, 32'd5}) begin
      bad++; $display("FAIL clean_counts rd=%0d fill=%0d stall=%0d exp rd=3 fill=1 stall=5",
                      rd_cnt, fill_cnt, stall_cnt);
    end
    req_addr = 32'h24;
    #1;
    total++;
    if (victim_way !== 1'b1) begin
      bad++; $display("FAIL clean_lru got=%b exp=1", victim_way);
    end
    step();
  endtask

  task automatic test_dirty_evict();
    int wr_cnt = 0, rd_cnt = 0, fill_cnt = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h104; hit = 1'b0;
    way_valid = 2'b11; victim_dirty = 1'b1; victim_tag = 28'h5; victim_data = 32'h1234;
    #1;
    total++;
    if ({stall, victim_way} !== 2'b11) begin
      bad++; $display("FAIL dirty_detect got=%b exp=11", {stall, victim_way});
    end
    step();
    req_valid = 1'b0; victim_dirty = 1'b0; victim_tag = 28'h7; victim_data = 32'h0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      mem_valid = (mem_write && wr_cnt == 1) || mem_read;
      mem_rdata = 32'hCAFEF00D;
      #1;
      if (mem_write) begin
        wr_cnt++;
        total++;
        if ({mem_read, mem_addr, mem_wdata} !== {1'b0, 32'h54, 32'h1234}) begin
          bad++; $display("FAIL dirty_wb got=%b/%h/%h exp=0/00000054/00001234",
                          mem_read, mem_addr, mem_wdata);
        end
      end
      if (mem_read) begin
        rd_cnt++;
        total++;
        if ({mem_addr, wr_cnt} !== {32'h104, 32'd2}) begin
          bad++; $display("FAIL dirty_rd got=%h wb_before=%0d exp=00000104 wb_before=2", mem_addr, wr_cnt);
        end
      end
      if (fill_en) begin
        fill_cnt++;
        total++;
        if ({fill_way, fill_data, fill_dirty, fill_tag} !== {1'b1, 32'hCAFEF00D, 1'b0, 28'h10}) begin
          bad++; $display("FAIL dirty_fill got=%b/%h/%b/%h exp=1/cafef00d/0/0000010",
                          fill_way, fill_data, fill_dirty, fill_tag);
        end
      end
      if (!stall) break;
      step();
    end
    mem_valid = 1'b0;
    total++;
    if ({wr_cnt, rd_cnt, fill_cnt} !== {32'd2, 32'd1, 32'd1}) begin
      bad++; $display("FAIL dirty_counts wr=%0d rd=%0d fill=%0d exp wr=2 rd=1 fill=1", wr_cnt, rd_cnt, fill_cnt);
    end
    req_addr = 32'h24;
    #1;
    total++;
    if (victim_way !== 1'b0) begin
      bad++; $display("FAIL dirty_lru got=%b exp=0", victim_way);
    end
    step();
  endtask

  task automatic test_store_miss();
    int wr_cnt = 0, rd_cnt = 0, fill_cnt = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hA5A5A5A5;
    hit = 1'b0; way_valid = 2'b11; victim_dirty = 1'b0; victim_tag = 28'h9; victim_data = 32'h77;
    #1;
    total++;
    if ({stall, victim_way} !== 2'b11) begin
      bad++; $display("FAIL store_detect got=%b exp=11", {stall, victim_way});
    end
    step();
    req_valid = 1'b0; req_write = 1'b0; req_wdata = 32'h0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      mem_valid = mem_read;
      mem_rdata = 32'h11111111;
      #1;
      if (mem_write) wr_cnt++;
      if (mem_read) begin
        rd_cnt++;
        total++;
        if (mem_addr !== 32'h30) begin
          bad++; $display("FAIL store_rd_addr got=%h exp=00000030", mem_addr);
        end
      end
      if (fill_en) begin
        fill_cnt++;
        total++;
        if ({fill_way, fill_data, fill_dirty, fill_tag} !== {1'b1, 32'hA5A5A5A5, 1'b1, 28'h3}) begin
          bad++; $display("FAIL store_fill got=%b/%h/%b/%h exp=1/a5a5a5a5/1/0000003",
                          fill_way, fill_data, fill_dirty, fill_tag);
        end
      end
      if (!stall) break;
      step();
    end
    mem_valid = 1'b0;
    total++;
    if ({wr_cnt, rd_cnt, fill_cnt} !== {32'd0, 32'd1, 32'd1}) begin
      bad++; $display("FAIL store_counts wr=%0d rd=%0d fill=%0d exp wr=0 rd=1 fill=1", wr_cnt, rd_cnt, fill_cnt);
    end
    req_addr = 32'h30;
    #1;
    total++;
    if (victim_way !== 1'b0) begin
      bad++; $display("FAIL store_lru got=%b exp=0", victim_way);
    end
    step();
  endtask

  task automatic test_mem_valid_idle();
    req_valid = 1'b0; hit = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({stall, mem_read, mem_write, fill_en} !== 4'b0000) begin
        bad++; $display("FAIL idle_mem_valid cyc=%0d got=%b exp=0000", i, {stall, mem_read, mem_write, fill_en});
      end
      step();
    end
    mem_valid = 1'b0;
    #1;
    total++;
    if ({stall, mem_read, mem_write, fill_en} !== 4'b0000) begin
      bad++; $display("FAIL idle_after got=%b exp=0000", {stall, mem_read, mem_write, fill_en});
    end
    step();
  endtask

  task automatic test_reset_refill();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h24; hit = 1'b0;
    way_valid = 2'b00; victim_dirty = 1'b0; mem_valid = 1'b0;
    step();
    req_valid = 1'b0;
    #1;
    total++;
    if ({mem_read, stall} !== 2'b11) begin
      bad++; $display("FAIL rr_in_refill got=%b exp=11", {mem_read, stall});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_read, stall, mem_addr} !== {2'b00, 32'h0}) begin
      bad++; $display("FAIL rr_abort got=%b/%b/%h exp=0/0/00000000", mem_read, stall, mem_addr);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    total++;
    if ({stall, mem_read, mem_write, fill_en} !== 4'b0000) begin
      bad++; $display("FAIL rr_idle got=%b exp=0000", {stall, mem_read, mem_write, fill_en});
    end
    way_valid = 2'b11;
    for (int s = 0; s < 4; s++) begin
      req_addr = s << 2;
      #1;
      total++;
      if (victim_way !== 1'b0) begin
        bad++; $display("FAIL rr_lru set=%0d got=%b exp=0", s, victim_way);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_clean_miss();
    test_dirty_evict();
    test_store_miss();
    test_mem_valid_idle();
    test_reset_refill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
